// File: rtl/npc_pkg.sv
// Shared types for the next-PC fetch unit: FSM states, next-PC source select
// and the default reset vector.
package npc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } fetchState_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } npcSel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_fetch_if.sv
// Instruction-memory read port: a request/address pair answered by an ack
// carrying the instruction word.
interface npc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/npc_calc.sv
// Purely combinational next-PC selection: jr > j/jal > taken branch > pc+4,
// plus detection of a misaligned register target.
module npc_calc
  import npc_pkg::*;
(
  input  logic        [31:0] pc,
  input  logic               br_valid,
  input  logic               br_taken,
  input  logic signed [31:0] br_off,
  input  logic               jmp_valid,
  input  logic        [25:0] jmp_index,
  input  logic               jr_valid,
  input  logic        [31:0] jr_addr,
  output logic        [31:0] nextPc,
  output npcSel_e            sel,
  output logic               misalign
);

  function automatic logic [31:0] addWrap(input logic [31:0] a,
                                          input logic signed [31:0] b);
    logic signed [31:0] sum;
    sum = $signed(a) + b;
    return $unsigned(sum);
  endfunction

  logic [31:0] pcPlus4;
  logic [31:0] brTarget;
  logic [31:0] jTarget;

  assign pcPlus4  = addWrap(pc, 32'sd4);
  assign brTarget = addWrap(pcPlus4, br_off);
  assign jTarget  = {pcPlus4[31:28], jmp_index, 2'b00};
  assign misalign = jr_valid && (jr_addr[1:0] != 2'b00);

  always_comb begin
    sel    = SEL_SEQ;
    nextPc = pcPlus4;
    if (jr_valid) begin
      sel    = SEL_JR;
      nextPc = wordAlign(jr_addr);
    end else if (jmp_valid) begin
      sel    = SEL_J;
      nextPc = jTarget;
    end else if (br_valid && br_taken) begin
      sel    = SEL_BR;
      nextPc = brTarget;
    end
  end

endmodule

// File: rtl/npc_fetch.sv
// Fetch unit: holds pc, issues one instruction-memory read per instruction and
// advances pc from the redirect inputs when the held instruction is consumed.
module npc_fetch
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               br_valid,
  input  logic               br_taken,
  input  logic signed [31:0] br_off,
  input  logic               jmp_valid,
  input  logic        [25:0] jmp_index,
  input  logic               jr_valid,
  input  logic        [31:0] jr_addr,
  input  logic               stall,
  npc_fetch_if.master        imem,
  output logic               inst_valid,
  output logic        [31:0] inst,
  output logic        [31:0] pc,
  output logic        [31:0] pc_plus4,
  output logic               misalign_err
);

  fetchState_e state, stateNext;
  logic        idleSeen;
  logic [31:0] pcReg;
  logic [31:0] instReg;
  logic        misalignReg;
  logic [31:0] nextPc;
  npcSel_e     sel;
  logic        misalign;
  logic        consume;
  logic        capture;

  npc_calc u_calc (
    .pc        (pcReg),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .jmp_valid (jmp_valid),
    .jmp_index (jmp_index),
    .jr_valid  (jr_valid),
    .jr_addr   (jr_addr),
    .nextPc    (nextPc),
    .sel       (sel),
    .misalign  (misalign)
  );

  assign consume = (state == S_VALID) && !stall;
  assign capture = (state == S_FETCH) && imem.imem_ack;

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (idleSeen) stateNext = S_FETCH;
      S_FETCH: if (imem.imem_ack) stateNext = S_VALID;
      S_VALID: if (!stall) stateNext = S_FETCH;
      default: stateNext = S_IDLE;
    endcase
  end

  // idleSeen stretches S_IDLE to one full cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idleSeen    <= 1'b0;
      pcReg       <= RESET_PC;
      instReg     <= '0;
      misalignReg <= 1'b0;
    end else begin
      state       <= stateNext;
      idleSeen    <= (state == S_IDLE);
      misalignReg <= consume && (sel == SEL_JR) && misalign;
      if (consume) pcReg <= nextPc;
      if (capture) instReg <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pcReg;
  assign inst_valid     = (state == S_VALID);
  assign inst           = instReg;
  assign pc             = pcReg;
  assign pc_plus4       = pcReg + 32'd4;
  assign misalign_err   = misalignReg;

endmodule

// File: tb/tb_npc_fetch.sv
// Directed and randomized checks of npc_fetch against a next-PC reference
// model built from the address-selection rules.
module tb_npc_fetch;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0, br_taken = 1'b0;
  logic [31:0] br_off = '0;
  logic        jmp_valid = 1'b0;
  logic [25:0] jmp_index = '0;
  logic        jr_valid = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        stall = 1'b0;
  logic        inst_valid, misalign_err;
  logic [31:0] inst, pc, pc_plus4;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] modelPc;
  logic [31:0] heldInst;

  npc_fetch_if bus ();

  npc_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_taken(br_taken), .br_off(br_off),
    .jmp_valid(jmp_valid), .jmp_index(jmp_index),
    .jr_valid(jr_valid), .jr_addr(jr_addr), .stall(stall),
    .imem(bus.master),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refNext(input logic [31:0] p, input logic jrv,
      input logic [31:0] jra, input logic jv, input logic [25:0] ji,
      input logic bv, input logic bt, input logic [31:0] bo);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (jrv) return jra - (jra % 32'd4);
    if (jv) return (p4 / 32'h1000_0000) * 32'h1000_0000 + {6'd0, ji} * 32'd4;
    if (bv && bt) return p4 + bo;
    return p4;
  endfunction

  // Expects a pending request for modelPc; answers it after dly idle cycles.
  task automatic fetch(input int dly);
    logic [31:0] data;
    data = $urandom;
    check("reqHigh", {31'd0, bus.imem_req}, 32'd1);
    check("reqAddr", bus.imem_addr, modelPc);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      check("waitReq", {31'd0, bus.imem_req}, 32'd1);
      check("waitAddr", bus.imem_addr, modelPc);
      check("waitNoValid", {31'd0, inst_valid}, 32'd0);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    heldInst = data;
    check("instValid", {31'd0, inst_valid}, 32'd1);
    check("instWord", inst, data);
    check("pcHeld", pc, modelPc);
    check("pcPlus4", pc_plus4, modelPc + 32'd4);
    check("reqDrop", {31'd0, bus.imem_req}, 32'd0);
    check("misIdle", {31'd0, misalign_err}, 32'd0);
  endtask

  task automatic consume(input logic jrv, input logic [31:0] jra, input logic jv,
      input logic [25:0] ji, input logic bv, input logic bt, input logic [31:0] bo);
    logic expMis;
    jr_valid = jrv; jr_addr = jra; jmp_valid = jv; jmp_index = ji;
    br_valid = bv; br_taken = bt; br_off = bo; stall = 1'b0;
    expMis = jrv && (jra[1:0] != 2'b00);
    @(negedge clk);
    jr_valid = 1'b0; jmp_valid = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    jr_addr = $urandom; br_off = $urandom; jmp_index = 26'($urandom);
    modelPc = refNext(modelPc, jrv, jra, jv, ji, bv, bt, bo);
    check("nextPc", pc, modelPc);
    check("consumedValid", {31'd0, inst_valid}, 32'd0);
    check("misPulse", {31'd0, misalign_err}, {31'd0, expMis});
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    modelPc = RPC;
    repeat (2) @(negedge clk);
    check("rstReq", {31'd0, bus.imem_req}, 32'd0);
    check("rstValid", {31'd0, inst_valid}, 32'd0);
    check("rstPc", pc, RPC);
    check("rstInst", inst, 32'd0);
    check("rstMis", {31'd0, misalign_err}, 32'd0);
    check("rstPc4", pc_plus4, RPC + 32'd4);

    rst_n = 1'b1;
    @(negedge clk);
    check("idleReq", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    fetch(1);
    consume(0, 0, 0, 0, 0, 0, 0);
    fetch(1);
    consume(0, 0, 0, 0, 0, 0, 0);
    check("seq3", bus.imem_addr, 32'h0040_0008);
    fetch(0);
    consume(0, 0, 0, 0, 0, 0, 0);
    fetch(2);
    consume(0, 0, 0, 0, 0, 0, 0);
    check("at10", pc, 32'h0040_0010);
    fetch(0);
    consume(0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8);
    check("brBack", bus.imem_addr, 32'h0040_000C);
    fetch(0);
    consume(1, 32'h0040_0010, 0, 0, 0, 0, 0);
    fetch(0);
    consume(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF8);
    check("brNotTaken", bus.imem_addr, 32'h0040_0014);
    fetch(0);
    consume(0, 0, 0, 0, 0, 1, 32'h0000_0100);
    check("takenNoValid", bus.imem_addr, 32'h0040_0018);
    fetch(0);
    consume(1, 32'h0040_0020, 0, 0, 0, 0, 0);
    fetch(1);
    consume(0, 0, 1, 26'h010_0040, 1, 1, 32'h0000_0040);
    check("jumpWins", bus.imem_addr, 32'h0040_0100);
    fetch(0);
    consume(1, 32'h0040_0123, 1, 26'h3, 1, 1, 32'h4);
    check("jrAlign", bus.imem_addr, 32'h0040_0120);
    @(negedge clk);
    check("misOneCycle", {31'd0, misalign_err}, 32'd0);
    fetch(0);

    // Stalled instruction ignores redirects and late acks.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jr_valid = i[0]; jr_addr = $urandom; jmp_valid = 1'b1; jmp_index = 26'($urandom);
      br_valid = 1'b1; br_taken = 1'b1; br_off = $urandom;
      bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
      @(negedge clk);
      check("stallInst", inst, heldInst);
      check("stallPc", pc, modelPc);
      check("stallReq", {31'd0, bus.imem_req}, 32'd0);
      check("stallValid", {31'd0, inst_valid}, 32'd1);
    end
    bus.imem_ack = 1'b0;
    consume(0, 0, 0, 0, 1, 1, 32'h0000_0020);

    fetch(0);
    consume(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    fetch(0);
    check("wrapPc4", pc_plus4, 32'd0);
    consume(0, 0, 0, 0, 0, 0, 0);
    check("wrapPc", pc, 32'd0);

    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [31:0] ra, ro;
      logic [25:0] ri;
      fetch(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        stall = 1'b1;
        @(negedge clk);
        check("rndStallPc", pc, modelPc);
      end
      kind = int'($urandom_range(0, 4));
      ra = $urandom; ri = 26'($urandom);
      ro = {{14{ra[15]}}, ra[15:0], 2'b00};
      consume(kind == 0, ra, kind == 1, ri, kind == 2 || kind == 3,
              kind == 2 || kind == 4, ro);
    end

    // Reset during a slow fetch, then a stale ack while idle.
    repeat (2) begin
      @(negedge clk);
      check("slowReq", {31'd0, bus.imem_req}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("midRstReq", {31'd0, bus.imem_req}, 32'd0);
    check("midRstPc", pc, RPC);
    check("midRstValid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("staleValid", {31'd0, inst_valid}, 32'd0);
    check("staleInst", inst, 32'd0);
    check("staleReq", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    modelPc = RPC;
    fetch(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
